// File: rtl/screen_dump.sv
// screen_dump: reads the whole text VRAM and streams it out as 8N1 UART,
// row by row, with CR LF after each row. Owns the VRAM port while o_running.
// Optional build macro SCREEN_DUMP_TRIM_EN: each row is first scanned and
// trailing blanks (0x00/0x20) are not transmitted.
//
// state | meaning
// IDLE  | waiting for i_start
// SCAN  | (trim build) pipelined read of the whole row, track last non-blank col
// FETCH | issue one VRAM read at {row,col}
// WAIT  | RD_LAT cycles of read latency, capture on the last one
// SEND  | transmit the captured character
// CR    | transmit 0x0D
// LF    | transmit 0x0A, then next row or IDLE
module screen_dump #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115200,
    parameter int COLS   = 60,
    parameter int ROWS   = 17,
    parameter int RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_running,
    output logic [10:0] o_vram_addr,
    output logic        o_vram_ce,
    output logic        o_vram_w,
    input  logic [7:0]  i_vram_dout,
    output logic        o_tx
);
    localparam int          BIT_CYC   = CLK_HZ / BAUD;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
    localparam logic [5:0]  COL_LAST  = 6'(COLS - 1);
    localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
    localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_FETCH, S_WAIT, S_SEND, S_CR, S_LF
    } state_t;

`ifdef SCREEN_DUMP_TRIM_EN
    localparam state_t ROW_START = S_SCAN;
`else
    localparam state_t ROW_START = S_FETCH;
`endif

    state_t      r_state, w_next;
    logic [4:0]  r_row;
    logic [5:0]  r_col;
    logic [1:0]  r_wait;
    logic [10:0] r_addr_hold;
    logic [15:0] r_baud;
    logic [3:0]  r_bit;
    logic [8:0]  r_shift;
    logic        r_tx;

    logic        w_ce, w_tx_state, w_frame_done, w_load;
    logic [10:0] w_addr;
    logic [7:0]  w_char, w_load_byte;
    logic [5:0]  w_row_end;

`ifdef SCREEN_DUMP_TRIM_EN
    localparam logic [6:0] SCAN_LAST = 7'(COLS + RD_LAT - 1);
    logic [6:0] r_scan;
    logic [5:0] r_last;
    logic       r_any;
    logic       w_scan_hit, w_scan_done, w_any;
    logic [5:0] w_scan_rd_col;

    // Scan read data for col (r_scan - RD_LAT) arrives RD_LAT cycles after its issue.
    assign w_scan_hit    = (r_state == S_SCAN) && (r_scan >= 7'(RD_LAT)) &&
                           (i_vram_dout != 8'h00) && (i_vram_dout != 8'h20);
    assign w_scan_rd_col = 6'(r_scan - 7'(RD_LAT));
    assign w_scan_done   = (r_scan == SCAN_LAST);
    assign w_any         = r_any | w_scan_hit;
    assign w_row_end     = r_last;
    assign w_ce          = (r_state == S_FETCH) ||
                           ((r_state == S_SCAN) && (r_scan < 7'(COLS)));
    assign w_addr        = (r_state == S_FETCH) ? {r_row, r_col} : {r_row, r_scan[5:0]};
`else
    assign w_row_end     = COL_LAST;
    assign w_ce          = (r_state == S_FETCH);
    assign w_addr        = {r_row, r_col};
`endif

    assign w_tx_state   = (r_state == S_SEND) || (r_state == S_CR) || (r_state == S_LF);
    assign w_frame_done = w_tx_state && (r_baud == 16'd0) && (r_bit == 4'd0);
    assign w_char       = (i_vram_dout == 8'h00) ? 8'h20 : i_vram_dout;
    assign w_load       = ((w_next == S_SEND) || (w_next == S_CR) || (w_next == S_LF)) &&
                          (w_next != r_state);
    assign w_load_byte  = (w_next == S_CR) ? 8'h0D : (w_next == S_LF) ? 8'h0A : w_char;

    assign o_running   = (r_state != S_IDLE);
    assign o_vram_ce   = w_ce;
    assign o_vram_addr = w_ce ? w_addr : r_addr_hold;
    assign o_vram_w    = 1'b0;
    assign o_tx        = r_tx;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = ROW_START;
`ifdef SCREEN_DUMP_TRIM_EN
            S_SCAN:  if (w_scan_done) w_next = w_any ? S_FETCH : S_CR;
`endif
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  if (r_wait == 2'd0) w_next = S_SEND;
            S_SEND:  if (w_frame_done) w_next = (r_col == w_row_end) ? S_CR : S_FETCH;
            S_CR:    if (w_frame_done) w_next = S_LF;
            S_LF:    if (w_frame_done) w_next = (r_row == ROW_LAST) ? S_IDLE : ROW_START;
            default: w_next = S_IDLE;
        endcase
    end

    // Row/column walk, read-latency countdown and address hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row       <= 5'd0;
            r_col       <= 6'd0;
            r_wait      <= 2'd0;
            r_addr_hold <= 11'd0;
        end else begin
            if (w_ce) r_addr_hold <= w_addr;
            if (r_state == S_FETCH)                      r_wait <= WAIT_LAST;
            else if (r_state == S_WAIT && r_wait != 2'd0) r_wait <= r_wait - 2'd1;
            if (r_state == S_IDLE && w_next != S_IDLE) begin
                r_row <= 5'd0;
                r_col <= 6'd0;
            end else if (r_state == S_SEND && w_next == S_FETCH) begin
                r_col <= r_col + 6'd1;
            end else if (r_state == S_LF && w_next == ROW_START) begin
                r_row <= r_row + 5'd1;
                r_col <= 6'd0;
            end
        end
    end

`ifdef SCREEN_DUMP_TRIM_EN
    // Scan pass: issue counter and last non-blank column of the current row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan <= 7'd0;
            r_last <= 6'd0;
            r_any  <= 1'b0;
        end else if (r_state == S_SCAN) begin
            r_scan <= r_scan + 7'd1;
            if (w_scan_hit) begin
                r_any  <= 1'b1;
                r_last <= w_scan_rd_col;
            end
        end else begin
            r_scan <= 7'd0;
            r_any  <= 1'b0;
        end
    end
`endif

    // UART transmitter: start bit on load, then 8 data bits LSB first and stop bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx    <= 1'b1;
            r_shift <= 9'h1FF;
            r_bit   <= 4'd0;
            r_baud  <= 16'd0;
        end else if (w_load) begin
            r_tx    <= 1'b0;
            r_shift <= {1'b1, w_load_byte};
            r_bit   <= 4'd9;
            r_baud  <= BIT_LAST;
        end else if (w_tx_state) begin
            if (r_baud != 16'd0) begin
                r_baud <= r_baud - 16'd1;
            end else if (r_bit != 4'd0) begin
                r_tx    <= r_shift[0];
                r_shift <= {1'b1, r_shift[8:1]};
                r_bit   <= r_bit - 4'd1;
                r_baud  <= BIT_LAST;
            end else begin
                r_tx <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_screen_dump.sv
// tb_screen_dump: two screen_dump instances (RD_LAT=1 and RD_LAT=2) share one
// VRAM image; UART monitors decode both lines and the decoded streams are
// compared with a stream built directly from the VRAM contents.
module tb_screen_dump;
    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 250_000;
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int COLS    = 60;
    localparam int ROWS    = 8;
    localparam int LIMIT   = ROWS * (COLS + 2) * (10 * BIT_CYC + 4) + 200;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic        run_a, ce_a, we_a, tx_a, run_b, ce_b, we_b, tx_b;
    logic [10:0] addr_a, addr_b;
    logic [7:0]  dout_a, dout_b, s1_b;
    logic [7:0]  mem [0:2047];

    int  n_cmp = 0, n_bad = 0;
    bit  mon_en = 1'b0;
    byte unsigned rxq_a[$], rxq_b[$], expq[$];

    screen_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .COLS(COLS), .ROWS(ROWS), .RD_LAT(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_running(run_a),
        .o_vram_addr(addr_a), .o_vram_ce(ce_a), .o_vram_w(we_a),
        .i_vram_dout(dout_a), .o_tx(tx_a));

    screen_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .COLS(COLS), .ROWS(ROWS), .RD_LAT(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_running(run_b),
        .o_vram_addr(addr_b), .o_vram_ce(ce_b), .o_vram_w(we_b),
        .i_vram_dout(dout_b), .o_tx(tx_b));

    always #5 clk = ~clk;

    // VRAM models: data valid only RD_LAT cycles after a ce cycle, junk otherwise.
    always @(posedge clk) dout_a <= ce_a ? mem[addr_a] : 8'($urandom);
    always @(posedge clk) begin
        s1_b   <= ce_b ? mem[addr_b] : 8'($urandom);
        dout_b <= s1_b;
    end

    function automatic logic [10:0] va(input int r, input int c);
        return 11'(r * 64 + c);
    endfunction

    function automatic logic txv(input int id);
        return (id == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic runv(input int id);
        return (id == 0) ? run_a : run_b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address range and write strobe, checked on every read-issue cycle.
    always @(negedge clk) begin
        if (ce_a) begin
            chk("addr_col_lt_cols_a", 32'(addr_a[5:0] < 6'(COLS)), 32'd1);
            chk("addr_row_lt_rows_a", 32'(addr_a[10:6] < 5'(ROWS)), 32'd1);
            chk("vram_w_a", 32'(we_a), 32'd0);
        end
        if (ce_b) begin
            chk("addr_col_lt_cols_b", 32'(addr_b[5:0] < 6'(COLS)), 32'd1);
            chk("addr_row_lt_rows_b", 32'(addr_b[10:6] < 5'(ROWS)), 32'd1);
        end
    end

    // UART monitor: samples once per cycle, checks bit stability, stop bit,
    // busy flag and inter-frame gap, and queues the decoded byte.
    task automatic uart_mon(input int id, input int lat);
        logic [9:0] lvl;
        logic       stable, runok, exempt;
        int         gap, qn;
        byte unsigned lastb;
        forever begin
            gap = 0;
            while (txv(id) !== 1'b0) begin
                @(negedge clk);
                gap++;
            end
            qn    = (id == 0) ? rxq_a.size() : rxq_b.size();
            lastb = (qn == 0) ? 8'h00 : ((id == 0) ? rxq_a[qn-1] : rxq_b[qn-1]);
            exempt = 1'b0;
`ifdef SCREEN_DUMP_TRIM_EN
            exempt = (lastb == 8'h0A);
`endif
            if (mon_en && qn > 0 && !exempt) begin
                n_cmp++;
                assert (gap <= lat + 1) else begin
                    n_bad++;
                    $error("FAIL frame_gap(dut%0d): observed %0d cycles required <= %0d", id, gap, lat + 1);
                end
            end
            stable = 1'b1;
            runok  = 1'b1;
            for (int k = 0; k < 10; k++) begin
                lvl[k] = txv(id);
                for (int j = 0; j < BIT_CYC; j++) begin
                    if (txv(id) !== lvl[k]) stable = 1'b0;
                    if (runv(id) !== 1'b1) runok = 1'b0;
                    @(negedge clk);
                end
            end
            if (mon_en) begin
                chk($sformatf("bit_stable_dut%0d", id), 32'(stable), 32'd1);
                chk($sformatf("stop_bit_dut%0d", id), 32'(lvl[9]), 32'd1);
                chk($sformatf("running_in_frame_dut%0d", id), 32'(runok), 32'd1);
                if (id == 0) rxq_a.push_back(lvl[8:1]);
                else         rxq_b.push_back(lvl[8:1]);
            end
        end
    endtask

    initial uart_mon(0, 1);
    initial uart_mon(1, 2);

    // Expected byte stream straight from the VRAM image.
    task automatic build_expected();
        expq.delete();
        for (int r = 0; r < ROWS; r++) begin
            int last;
            last = COLS - 1;
`ifdef SCREEN_DUMP_TRIM_EN
            last = -1;
            for (int c = 0; c < COLS; c++)
                if (mem[va(r, c)] != 8'h00 && mem[va(r, c)] != 8'h20) last = c;
`endif
            for (int c = 0; c <= last; c++)
                expq.push_back((mem[va(r, c)] == 8'h00) ? 8'h20 : mem[va(r, c)]);
            expq.push_back(8'h0D);
            expq.push_back(8'h0A);
        end
    endtask

    task automatic run_dump(input string tag, input bit restart, input bit measure);
        int cyc, cyc_a, cyc_b, lowcnt;
        bit meas_done;
        build_expected();
        rxq_a.delete();
        rxq_b.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_running_rise_a"}, 32'(run_a), 32'd1);
        chk({tag, "_running_rise_b"}, 32'(run_b), 32'd1);
        cyc = 0; cyc_a = 1; cyc_b = 1; lowcnt = 0; meas_done = 1'b0;
        while ((run_a || run_b) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (run_a) cyc_a++;
            if (run_b) cyc_b++;
            if (!meas_done) begin
                if (tx_a === 1'b0) lowcnt++;
                else if (lowcnt > 0) meas_done = 1'b1;
            end
            if (restart && cyc == 3000 && run_a) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                cyc++; cyc_a++; cyc_b++;
            end
        end
        chk({tag, "_dump_timeout"}, 32'(cyc < LIMIT), 32'd1);
        if (measure) chk({tag, "_start_bit_cycles"}, 32'(lowcnt), 32'(BIT_CYC));
`ifndef SCREEN_DUMP_TRIM_EN
        chk({tag, "_duration_ok_a"}, 32'(cyc_a <= expq.size() * (10 * BIT_CYC + 2)), 32'd1);
        chk({tag, "_duration_ok_b"}, 32'(cyc_b <= expq.size() * (10 * BIT_CYC + 3)), 32'd1);
`endif
        repeat (3) @(negedge clk);
        chk({tag, "_tx_idle_a"}, 32'(tx_a), 32'd1);
        chk({tag, "_byte_count_a"}, 32'(rxq_a.size()), 32'(expq.size()));
        chk({tag, "_byte_count_b"}, 32'(rxq_b.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (i < rxq_a.size()) chk($sformatf("%s_byte%0d_a", tag, i), 32'(rxq_a[i]), 32'(expq[i]));
            if (i < rxq_b.size()) chk($sformatf("%s_byte%0d_b", tag, i), 32'(rxq_b[i]), 32'(expq[i]));
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mem[va(r, c)] = 8'(8'h41 + (c % 26));

        // Reset values.
        repeat (3) @(negedge clk);
        chk("reset_tx_a", 32'(tx_a), 32'd1);
        chk("reset_running_a", 32'(run_a), 32'd0);
        chk("reset_ce_a", 32'(ce_a), 32'd0);
        chk("reset_w_a", 32'(we_a), 32'd0);
        chk("reset_addr_a", 32'(addr_a), 32'd0);
        chk("reset_tx_b", 32'(tx_b), 32'd0 + 32'd1);
        chk("reset_running_b", 32'(run_b), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of the first frame, during data bit 1 of 'A' (low).
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (tx_a !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("midreset_start_seen", 32'(n < 100), 32'd1);
        repeat (2 * BIT_CYC + 1) @(negedge clk);
        chk("midreset_tx_low_before", 32'(tx_a), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_tx_high", 32'(tx_a), 32'd1);
        chk("midreset_running_low", 32'(run_a), 32'd0);
        chk("midreset_ce_low", 32'(ce_a), 32'd0);
        chk("midreset_addr_zero", 32'(addr_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("after_reset_idle_running", 32'(run_a | run_b), 32'd0);
        chk("after_reset_idle_tx", 32'(tx_a & tx_b), 32'd1);
        repeat (12 * BIT_CYC) @(negedge clk);
        mon_en = 1'b1;

        // Full dump of the letter pattern.
        run_dump("pattern", 1'b0, 1'b1);

        // Random contents with NULs, an all-NUL last row, and a start pulse mid-dump.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case ($urandom_range(0, 3))
                    0:       mem[va(r, c)] = 8'h00;
                    1:       mem[va(r, c)] = 8'h20;
                    default: mem[va(r, c)] = 8'($urandom_range(8'h21, 8'h7E));
                endcase
        for (int c = 0; c < COLS; c++) mem[va(ROWS - 1, c)] = 8'h00;
`ifdef SCREEN_DUMP_TRIM_EN
        for (int c = 0; c < COLS; c++) begin
            mem[va(0, c)] = 8'h20;
            mem[va(1, c)] = 8'h20;
        end
        mem[va(0, 0)] = 8'h48;
        mem[va(0, 1)] = 8'h49;
        mem[va(2, COLS - 1)] = 8'h5A;
`endif
        run_dump("random_nul", 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
